mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data requesters share one RAM port.
// Data wins by default; a waiting instruction fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        ram_err
);

  localparam int unsigned SW_MIN = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned SW     = (SW_MIN < 3) ? 3 : SW_MIN;
  localparam int unsigned CW_MIN = $clog2(TIMEOUT + 1);
  localparam int unsigned CW     = (CW_MIN < 1) ? 1 : CW_MIN;

  localparam logic [SW-1:0] STARVE_CNT  = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic [CW-1:0] r_cycles;
  logic          r_ram_ren;
  logic          r_ram_wen;
  logic [31:0]   r_ram_addr;
  logic [31:0]   r_ram_wdata;

  logic          w_dreq;
  logic          w_ipick;
  logic          w_busy;
  logic          w_expired;
  logic [SW-1:0] w_starve_inc;

  assign w_dreq       = dREN | dWEN;
  assign w_ipick      = iREN & (~w_dreq | (r_starve >= STARVE_CNT));
  assign w_busy       = (r_state != IDLE);
  assign w_expired    = (r_cycles == TIMEOUT_CNT);
  assign w_starve_inc = (&r_starve) ? r_starve : r_starve + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_cycles    <= '0;
      r_ram_ren   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cycles <= '0;
          if (w_ipick) begin
            r_state     <= IGRANT;
            r_ram_ren   <= 1'b1;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= iaddr;
            r_ram_wdata <= '0;
            r_starve    <= '0;
          end else if (w_dreq) begin
            // A combined read+write request is issued as a write.
            r_state     <= DGRANT;
            r_ram_ren   <= ~dWEN;
            r_ram_wen   <= dWEN;
            r_ram_addr  <= daddr;
            r_ram_wdata <= dstore;
            r_starve    <= iREN ? w_starve_inc : '0;
          end else begin
            r_starve    <= '0;
          end
        end
        IGRANT, DGRANT: begin
          if (ram_ack || w_expired) begin
            r_state   <= IDLE;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
            r_cycles  <= '0;
          end else begin
            r_cycles  <= r_cycles + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Completion and timeout follow ram_ack in the same cycle, so these decode state with the live ack.
  assign iwait     = ~((r_state == IGRANT) & ram_ack);
  assign dwait     = ~((r_state == DGRANT) & ram_ack);
  assign ram_err   = w_busy & ~ram_ack & w_expired;
  assign iload     = ram_rdata;
  assign dload     = ram_rdata;

  assign ram_ren   = r_ram_ren;
  assign ram_wen   = r_ram_wen;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all checked against
// a transaction-level reference model (owner / age / starve bookkeeping).
module tb_mem_arbiter;

  localparam int unsigned SLIM = 4;
  localparam int unsigned TO   = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        ram_err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(SLIM), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .ram_err(ram_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who owns the RAM (0 none, 1 instr, 2 data), how long it has waited.
  int          m_owner;
  int          m_age;
  int          m_starve;
  logic        m_ren, m_wen;
  logic [31:0] m_addr, m_wdata;

  // Stimulus control
  int   ack_delay;
  bit   stray_ack;
  bit   rdata_fix_en;
  int   i_mode, d_mode;
  int   cyc;
  logic prev_strobe;

  // Event log from observed DUT outputs
  int          g_cyc[$];
  int          g_kind[$];
  logic        g_wen[$];
  logic [31:0] g_wdata[$];
  int          err_cyc[$];
  int          iw_cyc[$];
  logic [31:0] iw_data[$];
  int          dw_cyc[$];

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_age    = 0;
    m_starve = 0;
    m_ren    = 1'b0;
    m_wen    = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
  endtask

  task automatic model_step();
    bit dreq;
    if (!nRST) begin
      model_reset();
      return;
    end
    dreq = dREN | dWEN;
    if (m_owner == 0) begin
      m_age = 0;
      if (iREN && (!dreq || m_starve >= SLIM)) begin
        m_owner = 1; m_ren = 1'b1; m_wen = 1'b0; m_addr = iaddr; m_starve = 0;
      end else if (dreq) begin
        m_owner = 2; m_wen = dWEN; m_ren = !dWEN; m_addr = daddr; m_wdata = dstore;
        m_starve = iREN ? m_starve + 1 : 0;
      end else begin
        m_starve = 0;
      end
    end else if (ram_ack || m_age == TO) begin
      m_owner = 0; m_ren = 1'b0; m_wen = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_reset_outputs();
    chk_b("rst_ram_ren", ram_ren, 1'b0);
    chk_b("rst_ram_wen", ram_wen, 1'b0);
    chk_w("rst_ram_addr", ram_addr, 32'h0);
    chk_w("rst_ram_wdata", ram_wdata, 32'h0);
    chk_b("rst_ram_err", ram_err, 1'b0);
    chk_b("rst_iwait", iwait, 1'b1);
    chk_b("rst_dwait", dwait, 1'b1);
  endtask

  task automatic clear_log();
    cyc = 0;
    prev_strobe = 1'b0;
    g_cyc.delete(); g_kind.delete(); g_wen.delete(); g_wdata.delete();
    err_cyc.delete(); iw_cyc.delete(); iw_data.delete(); dw_cyc.delete();
  endtask

  task automatic cycle();
    logic e_iw, e_dw, e_err, strobe;
    int   r;
    if (m_owner != 0)
      ram_ack = (ack_delay < 0) ? ($urandom_range(0, 3) == 0) : (m_age == ack_delay);
    else
      ram_ack = stray_ack && ($urandom_range(0, 2) == 0);
    ram_rdata = rdata_fix_en ? 32'h2402000A : $urandom;

    @(negedge CLK);
    e_iw  = !(m_owner == 1 && ram_ack);
    e_dw  = !(m_owner == 2 && ram_ack);
    e_err = (m_owner != 0) && !ram_ack && (m_age == TO);
    chk_b("iwait", iwait, e_iw);
    chk_b("dwait", dwait, e_dw);
    chk_b("ram_err", ram_err, e_err);
    chk_b("ram_ren", ram_ren, m_ren);
    chk_b("ram_wen", ram_wen, m_wen);
    if (m_owner != 0) chk_w("ram_addr", ram_addr, m_addr);
    if (m_owner == 2 && m_wen) chk_w("ram_wdata", ram_wdata, m_wdata);
    if (!e_iw) chk_w("iload", iload, ram_rdata);
    if (!e_dw && !m_wen) chk_w("dload", dload, ram_rdata);

    strobe = ram_ren | ram_wen;
    if (strobe && !prev_strobe) begin
      g_cyc.push_back(cyc);
      g_kind.push_back((ram_ren && !ram_wen && ram_addr == iaddr) ? 1 : 2);
      g_wen.push_back(ram_wen);
      g_wdata.push_back(ram_wdata);
    end
    prev_strobe = strobe;
    if (ram_err) err_cyc.push_back(cyc);
    if (!iwait) begin iw_cyc.push_back(cyc); iw_data.push_back(iload); end
    if (!dwait) dw_cyc.push_back(cyc);

    @(posedge CLK);
    model_step();
    #1;
    cyc++;

    if (!e_iw) iREN = (i_mode == 1);
    if (i_mode == 2) begin
      if (iREN && $urandom_range(0, 24) == 0) iREN = 1'b0;
      else if (!iREN && $urandom_range(0, 2) == 0) begin iREN = 1'b1; iaddr = $urandom; end
    end
    if (!e_dw && d_mode != 1) begin dREN = 1'b0; dWEN = 1'b0; end
    if (d_mode == 2) begin
      if ((dREN || dWEN) && $urandom_range(0, 24) == 0) begin
        dREN = 1'b0; dWEN = 1'b0;
      end else if (!(dREN || dWEN) && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 3);
        dREN = (r != 1); dWEN = (r == 1 || r == 2);
        daddr = $urandom; dstore = $urandom;
      end
    end
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ram_rdata = '0; ram_ack = 1'b0;
    ack_delay = -1; stray_ack = 1'b0; rdata_fix_en = 1'b0;
    i_mode = 0; d_mode = 0;
    model_reset();
    clear_log();

    #3;
    check_reset_outputs();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Single instruction fetch, ack two cycles after the strobe
    iaddr = 32'h100; iREN = 1'b1; ack_delay = 2; rdata_fix_en = 1'b1;
    clear_log();
    repeat (5) cycle();
    chk_i("A_grants", g_cyc.size(), 1);
    chk_i("A_ren_cycle", (g_cyc.size() > 0) ? g_cyc[0] : -1, 1);
    chk_i("A_iwait_low_count", iw_cyc.size(), 1);
    chk_i("A_iwait_low_cycle", (iw_cyc.size() > 0) ? iw_cyc[0] : -1, 3);
    chk_w("A_iload", (iw_data.size() > 0) ? iw_data[0] : 32'hX, 32'h2402000A);
    rdata_fix_en = 1'b0;

    // Instruction and data write together: data first, then instruction
    iaddr = 32'h100; iREN = 1'b1;
    daddr = 32'h200; dstore = 32'hDEADBEEF; dWEN = 1'b1; dREN = 1'b0;
    ack_delay = 1;
    clear_log();
    repeat (8) cycle();
    chk_i("B_grants", g_cyc.size(), 2);
    chk_i("B_first_kind", (g_kind.size() > 0) ? g_kind[0] : -1, 2);
    chk_b("B_first_wen", (g_wen.size() > 0) ? g_wen[0] : 1'bX, 1'b1);
    chk_w("B_first_wdata", (g_wdata.size() > 0) ? g_wdata[0] : 32'hX, 32'hDEADBEEF);
    chk_i("B_second_kind", (g_kind.size() > 1) ? g_kind[1] : -1, 1);
    chk_i("B_second_cycle", (g_cyc.size() > 1) ? g_cyc[1] : -1, 4);

    // Both held continuously: four data grants, one instruction, data resumes
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; i_mode = 1; d_mode = 1; ack_delay = 1;
    clear_log();
    repeat (21) cycle();
    chk_i("C_grants", g_kind.size(), 7);
    for (int k = 0; k < 7; k++)
      chk_i($sformatf("C_kind_%0d", k), (g_kind.size() > k) ? g_kind[k] : -1, (k == 4) ? 1 : 2);
    chk_i("C_spacing", (g_cyc.size() > 1) ? g_cyc[1] - g_cyc[0] : -1, 3);
    i_mode = 0; d_mode = 0; iREN = 1'b0; dREN = 1'b0;
    repeat (6) cycle();

    // Data read never acknowledged: timeout, return to idle, re-grant of the held request
    daddr = 32'h300; dREN = 1'b1; d_mode = 1; ack_delay = 1000;
    clear_log();
    repeat (14) cycle();
    chk_i("D_err_count", err_cyc.size(), 1);
    chk_i("D_err_cycle", (err_cyc.size() > 0) ? err_cyc[0] : -1, 9);
    chk_i("D_dwait_low_count", dw_cyc.size(), 0);
    chk_i("D_regrant_cycle", (g_cyc.size() > 1) ? g_cyc[1] : -1, 11);

    // Reset in the middle of the re-granted access, then idle with stray acks
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    dREN = 1'b0; d_mode = 0; stray_ack = 1'b1; ack_delay = -1;
    repeat (2) cycle();
    nRST = 1'b1;
    clear_log();
    repeat (8) cycle();
    chk_i("E_grants", g_cyc.size(), 0);
    chk_i("E_iwait_low", iw_cyc.size(), 0);
    chk_i("E_dwait_low", dw_cyc.size(), 0);

    // Randomized traffic from both requesters with random RAM latency
    i_mode = 2; d_mode = 2; stray_ack = 1'b1; ack_delay = -1;
    clear_log();
    repeat (3000) cycle();
    chk_b("R_saw_timeouts", err_cyc.size() > 0, 1'b1);
    i_mode = 0; d_mode = 0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (12) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
